alu181_nibble_sequencer: RTL
============================

// Module: alu181_nibble_sequencer
// PURPOSE
//  Nibble-serial front end for one 74LS181-style 4-bit ALU slice. It accepts a
//  WIDTH-bit operation over a valid/ready handshake and feeds the slice one nibble
//  per clock, LSB nibble first. Each cycle it registers the slice result F, passes
//  the active-low carry out into the next nibble's Cn, and ANDs the A=B outputs
//  together. The assembled result is returned on a valid/ready output handshake.
//  This block sits directly in front of the combinational slice and behind it.
// PARAMETERS
//  WIDTH    16   operand/result width; multiple of 4, >=4 (NIBBLES = WIDTH/4)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operation request
//  in_ready     out  1      sequencer can accept a request (high in IDLE)
//  op_a         in   WIDTH  operand A
//  op_b         in   WIDTH  operand B
//  op_sel       in   4      function select S3..S0
//  op_mode      in   1      M: 1 = logic, 0 = arithmetic
//  op_cin_n     in   1      carry in, active-low (Cn)
//  alu_a        out  4      slice A nibble
//  alu_b        out  4      slice B nibble
//  alu_s        out  4      slice select
//  alu_m        out  1      slice mode
//  alu_cn       out  1      slice carry in, active-low
//  alu_f        in   4      slice F result
//  alu_cout_n   in   1      slice Cn+4, active-low
//  alu_aeqb     in   1      slice A=B
//  out_valid    out  1      result available
//  out_ready    in   1      consumer accepts result
//  result       out  WIDTH  assembled F
//  carry_out_n  out  1      Cn+4 of the top nibble, active-low
//  a_eq_b       out  1      AND of A=B over all nibbles
// BEHAVIOUR
//  - FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: on in_valid, register op_a/op_b/op_sel/op_mode; set carry_r=op_cin_n,
//    eq_r=1, cnt=0; go to RUN.
//  - RUN: alu_a=a_r[4*cnt+:4], alu_b=b_r[4*cnt+:4], alu_s=sel_r, alu_m=mode_r,
//    alu_cn=carry_r. All are registered or muxed from registers; no input-to-output
//    combinational path.
//  - RUN, each rising edge: result[4*cnt+:4]<=alu_f; carry_r<=alu_cout_n;
//    eq_r<=eq_r&alu_aeqb; cnt<=cnt+1. At cnt==NIBBLES-1, go to DONE and do not wrap.
//  - The carry chains in M=1 as well. carry_out_n always reports the top slice's Cn+4.
//  - DONE: result, carry_out_n=carry_r and a_eq_b=eq_r stay stable until out_ready.
//    Then go to IDLE. in_valid is ignored outside IDLE.
//  - Outside RUN: alu_a=alu_b=alu_s=0, alu_m=1, alu_cn=1.
//  - Latency: out_valid rises NIBBLES cycles after the accepting edge.
//    Throughput is one op per NIBBLES+2 cycles when out_ready is held high.
//  - Reset values: state=IDLE, result=0, carry_out_n=1, a_eq_b=0, out_valid=0,
//    in_ready=1 after release, alu_* at the idle values above.
//  - Reset asserted mid-RUN or in DONE: the partial result is discarded and
//    out_valid drops immediately.
// CONFIGURATION
//  ALU181_ZERO_FLAG_EN defined: adds output zero (1 bit), registered with the
//    result. zero=1 iff every captured nibble==0. Reset value 0. Valid in DONE.
//  Undefined: no zero port and no zero logic.
// TESTING
//  1 M=0,S=1001,Cn_n=1,A=1234,B=0FCD -> result=2201, carry_out_n=1, out_valid 4 clk after accept
//  2 M=0,S=1001,Cn_n=1,A=FFFF,B=0001 -> result=0000, carry_out_n=0 (ripple across all 4 nibbles)
//  3 M=0,S=0110,Cn_n=1,A=B=5A5A -> result=FFFF, a_eq_b=1; A=5A5B -> a_eq_b=0
//  4 M=1,S=1011,A=F0F0,B=FF00 -> result=F000; alu_m=1 on every RUN cycle
//  5 out_ready=0 for 5 clk in DONE -> result/flags stable, in_ready=0, new in_valid ignored
//  6 rst_n low at RUN cnt=2 -> out_valid=0, result=0 at once; next op completes correctly;
//    with ALU181_ZERO_FLAG_EN, A=B=0000 add gives zero=1

Source files
------------

// File: rtl/alu181_nibble_sequencer.sv
// rtl/alu181_nibble_sequencer.sv - nibble-serial sequencer for one 74LS181-style ALU slice
// Optional zero flag output enabled by defining ALU181_ZERO_FLAG_EN.
module alu181_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_sel,
  input  logic             op_mode,
  input  logic             op_cin_n,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout_n,
  input  logic             alu_aeqb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out_n,
  output logic             a_eq_b
`ifdef ALU181_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW+1:0]    base;
  logic             run;

  assign run  = (state_q == ST_RUN);
  assign base = {cnt_q, 2'b00};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sel_d   = op_sel;
          mode_d  = op_mode;
          carry_d = op_cin_n;
          eq_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry ripples in logic mode too so carry_out_n always mirrors the top slice.
        result_d[base +: 4] = alu_f;
        carry_d             = alu_cout_n;
        eq_d                = eq_q & alu_aeqb;
        if (cnt_q == CW'(NIBBLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b1;
      carry_q  <= 1'b1;
      eq_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

`ifdef ALU181_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == ST_IDLE && in_valid) begin
      zero_d = 1'b1;
    end else if (run) begin
      zero_d = zero_q & (alu_f == 4'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

  // Slice drive comes only from registers, so there is no in-to-out combinational path.
  assign alu_a  = run ? a_q[base +: 4] : 4'h0;
  assign alu_b  = run ? b_q[base +: 4] : 4'h0;
  assign alu_s  = run ? sel_q : 4'h0;
  assign alu_m  = run ? mode_q : 1'b1;
  assign alu_cn = run ? carry_q : 1'b1;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign carry_out_n = carry_q;
  assign a_eq_b      = eq_q;

endmodule
